// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the ID-stage branch controller: branch types, FSM states
// and small decode helpers used by the controller and its hazard detector.
package mips_ctrl_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_BEQ  = 3'b001,
        BR_BNE  = 3'b010,
        BR_BLTZ = 3'b011,
        BR_BGEZ = 3'b100,
        BR_BLEZ = 3'b101,
        BR_BGTZ = 3'b110,
        BR_RSVD = 3'b111
    } br_type_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } br_state_e;

    function automatic logic is_branch(input logic [2:0] br);
        return (br != BR_NONE) && (br != BR_RSVD);
    endfunction

    function automatic logic uses_rt(input logic [2:0] br);
        return (br == BR_BEQ) || (br == BR_BNE);
    endfunction

    // The single-operand compares (bltz..bgtz) evaluate rs against zero.
    function automatic logic cmp_zero(input logic [2:0] br);
        return (br == BR_BLTZ) || (br == BR_BGEZ) || (br == BR_BLEZ) || (br == BR_BGTZ);
    endfunction

    function automatic logic branch_taken(input logic [2:0] br, input logic eq, input logic ltz);
        case (br)
            BR_BEQ:  return eq;
            BR_BNE:  return !eq;
            BR_BLTZ: return ltz;
            BR_BGEZ: return !ltz;
            BR_BLEZ: return ltz || eq;
            BR_BGTZ: return !ltz && !eq;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Bus between the ID stage and the branch controller. When BRCTRL_PERF_EN is
// defined the bus also carries the stall and taken-branch counters.
interface branch_resolve_ctrl_if #(
    parameter int REG_AW = 5
);
    logic [2:0]        BrTypeD;
    logic [REG_AW-1:0] RsD;
    logic [REG_AW-1:0] RtD;
    logic              RegWriteE;
    logic              MemtoRegE;
    logic [REG_AW-1:0] WriteRegE;
    logic              RegWriteM;
    logic              MemtoRegM;
    logic [REG_AW-1:0] WriteRegM;
    logic              HoldIn;
    logic              EqualD;
    logic              LtzD;
    logic              ForwardAD;
    logic              ForwardBD;
    logic              CmpBZeroD;
    logic              StallF;
    logic              StallD;
    logic              FlushE;
    logic              PCSrcD;
    logic              FlushD;
`ifdef BRCTRL_PERF_EN
    logic [31:0]       BrStallCnt;
    logic [31:0]       BrTakenCnt;

    modport master (
        output BrTypeD, RsD, RtD, RegWriteE, MemtoRegE, WriteRegE,
               RegWriteM, MemtoRegM, WriteRegM, HoldIn, EqualD, LtzD,
        input  ForwardAD, ForwardBD, CmpBZeroD, StallF, StallD, FlushE,
               PCSrcD, FlushD, BrStallCnt, BrTakenCnt
    );

    modport slave (
        input  BrTypeD, RsD, RtD, RegWriteE, MemtoRegE, WriteRegE,
               RegWriteM, MemtoRegM, WriteRegM, HoldIn, EqualD, LtzD,
        output ForwardAD, ForwardBD, CmpBZeroD, StallF, StallD, FlushE,
               PCSrcD, FlushD, BrStallCnt, BrTakenCnt
    );
`else
    modport master (
        output BrTypeD, RsD, RtD, RegWriteE, MemtoRegE, WriteRegE,
               RegWriteM, MemtoRegM, WriteRegM, HoldIn, EqualD, LtzD,
        input  ForwardAD, ForwardBD, CmpBZeroD, StallF, StallD, FlushE,
               PCSrcD, FlushD
    );

    modport slave (
        input  BrTypeD, RsD, RtD, RegWriteE, MemtoRegE, WriteRegE,
               RegWriteM, MemtoRegM, WriteRegM, HoldIn, EqualD, LtzD,
        output ForwardAD, ForwardBD, CmpBZeroD, StallF, StallD, FlushE,
               PCSrcD, FlushD
    );
`endif
endinterface

// File: rtl/branch_resolve_ctrl_hazard.sv
// Combinational hazard check for a branch in ID: how many stall cycles it needs
// before its operands are reachable, and which operands come from the MEM ALU result.
module branch_hazard_detect
    import mips_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [2:0]        br_type,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic              reg_write_e,
    input  logic              mem_to_reg_e,
    input  logic [REG_AW-1:0] write_reg_e,
    input  logic              reg_write_m,
    input  logic              mem_to_reg_m,
    input  logic [REG_AW-1:0] write_reg_m,
    output logic [1:0]        need,
    output logic              fwd_a,
    output logic              fwd_b
);
    localparam logic [REG_AW-1:0] ZERO = REG_AW'(REG_ZERO);

    logic rt_used;
    logic h_e;
    logic h_m;

    // A load still in EX is two cycles away; an ALU result in EX or a load in MEM is one.
    always_comb begin
        rt_used = uses_rt(br_type);
        h_e = reg_write_e && (write_reg_e != ZERO) &&
              ((write_reg_e == rs) || (rt_used && (write_reg_e == rt)));
        h_m = reg_write_m && (write_reg_m != ZERO) &&
              ((write_reg_m == rs) || (rt_used && (write_reg_m == rt)));

        need = 2'd0;
        if (h_e && mem_to_reg_e) begin
            need = 2'd2;
        end else if (h_e || (h_m && mem_to_reg_m)) begin
            need = 2'd1;
        end

        fwd_a = reg_write_m && !mem_to_reg_m && (write_reg_m == rs) && (rs != ZERO);
        fwd_b = reg_write_m && !mem_to_reg_m && (write_reg_m == rt) && (rt != ZERO);
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch resolution controller: stall sequencing, comparator operand selects
// and the taken decision. Define BRCTRL_PERF_EN to add the BrStallCnt/BrTakenCnt counters.
module branch_resolve_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int MAX_WAIT = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    branch_resolve_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    br_state_e        state_q;
    br_state_e        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic [1:0] need;
    logic       fwd_a;
    logic       fwd_b;

    logic fwd_a_o;
    logic fwd_b_o;
    logic cmp_zero_o;
    logic stall_f_o;
    logic stall_d_o;
    logic flush_e_o;
    logic pc_src_o;
    logic flush_d_o;

    branch_hazard_detect #(.REG_AW(REG_AW)) u_hazard (
        .br_type      (bus.BrTypeD),
        .rs           (bus.RsD),
        .rt           (bus.RtD),
        .reg_write_e  (bus.RegWriteE),
        .mem_to_reg_e (bus.MemtoRegE),
        .write_reg_e  (bus.WriteRegE),
        .reg_write_m  (bus.RegWriteM),
        .mem_to_reg_m (bus.MemtoRegM),
        .write_reg_m  (bus.WriteRegM),
        .need         (need),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b)
    );

    // In WAIT, cnt is the number of stall cycles still owed including the current one.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fwd_a_o    = 1'b0;
        fwd_b_o    = 1'b0;
        cmp_zero_o = 1'b0;
        stall_f_o  = 1'b0;
        stall_d_o  = 1'b0;
        flush_e_o  = 1'b0;
        pc_src_o   = 1'b0;
        flush_d_o  = 1'b0;

        if (rst_n) begin
            if (bus.HoldIn) begin
                stall_f_o = 1'b1;
                stall_d_o = 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (is_branch(bus.BrTypeD)) begin
                            if (need != 2'd0) begin
                                stall_f_o = 1'b1;
                                stall_d_o = 1'b1;
                                flush_e_o = 1'b1;
                                cnt_d     = CNT_W'(need - 2'd1);
                                state_d   = (need == 2'd2) ? ST_WAIT : ST_IDLE;
                            end else begin
                                fwd_a_o    = fwd_a;
                                fwd_b_o    = fwd_b;
                                cmp_zero_o = cmp_zero(bus.BrTypeD);
                                pc_src_o   = branch_taken(bus.BrTypeD, bus.EqualD, bus.LtzD);
                                flush_d_o  = pc_src_o;
                            end
                        end
                    end
                    ST_WAIT: begin
                        stall_f_o = 1'b1;
                        stall_d_o = 1'b1;
                        flush_e_o = 1'b1;
                        if (cnt_q <= CNT_W'(1)) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ForwardAD = fwd_a_o;
    assign bus.ForwardBD = fwd_b_o;
    assign bus.CmpBZeroD = cmp_zero_o;
    assign bus.StallF    = stall_f_o;
    assign bus.StallD    = stall_d_o;
    assign bus.FlushE    = flush_e_o;
    assign bus.PCSrcD    = pc_src_o;
    assign bus.FlushD    = flush_d_o;

`ifdef BRCTRL_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] taken_cnt_q;
    logic [31:0] taken_cnt_d;

    // Held cycles are not branch stalls, so they are excluded from the stall count.
    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, stall_d_o & ~bus.HoldIn};
        taken_cnt_d = taken_cnt_q + {31'd0, pc_src_o};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            taken_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign bus.BrStallCnt = stall_cnt_q;
    assign bus.BrTakenCnt = taken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl: a pipeline-level model pushes the expected
// per-cycle outputs, and a negedge monitor pops and compares them against the DUT.
module tb_branch_resolve_ctrl;
    import mips_ctrl_pkg::*;

    // kind: 0 = no writer, 1 = ALU result, 2 = load
    typedef struct {
        int         kind;
        logic [4:0] dest;
    } prod_t;

    typedef struct {
        logic [7:0] v;
        string      tag;
    } exp_t;

    logic        clk;
    logic        rst_n;
    exp_t        exp_q[$];
    int          tests_run = 0;
    int          tests_failed = 0;
    int unsigned model_stall_cnt = 0;
    int unsigned model_taken_cnt = 0;

    branch_resolve_ctrl_if #(.REG_AW(5)) br_if ();

    branch_resolve_ctrl #(.REG_AW(5), .MAX_WAIT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (br_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output vector order: ForwardAD ForwardBD CmpBZeroD StallF StallD FlushE PCSrcD FlushD
    function automatic logic [7:0] observed();
        return {br_if.ForwardAD, br_if.ForwardBD, br_if.CmpBZeroD, br_if.StallF,
                br_if.StallD, br_if.FlushE, br_if.PCSrcD, br_if.FlushD};
    endfunction

    task automatic checkOutput(input exp_t e);
        logic [7:0] got;
        got = observed();
        tests_run++;
        if (got !== e.v) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %b, expected %b (fA fB cz sF sD fE pc fD)", e.tag, got, e.v);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) checkOutput(exp_q.pop_front());
    end

    task automatic push_expected(input logic [7:0] v, input string tag, input bit hold);
        exp_t e;
        e.v   = v;
        e.tag = tag;
        exp_q.push_back(e);
        if (v[3] && !hold) model_stall_cnt++;
        if (v[1]) model_taken_cnt++;
    endtask

    task automatic applyStimulus(input logic [7:0] v, input string tag, input int n_hold);
        for (int i = 0; i < n_hold; i++) begin
            br_if.HoldIn = 1'b1;
            push_expected(8'b0001_1000, $sformatf("%s/hold%0d", tag, i), 1'b1);
            @(posedge clk);
            #1;
        end
        br_if.HoldIn = 1'b0;
        push_expected(v, tag, 1'b0);
        @(posedge clk);
        #1;
    endtask

    function automatic int hold_count(input int idx, input int hold_at, input bit rand_holds);
        if (idx == hold_at) return 3;
        if (rand_holds && ($urandom_range(0, 5) == 0)) return int'($urandom_range(1, 3));
        return 0;
    endfunction

    function automatic bit reads_reg(input logic [4:0] d, input logic [4:0] rs,
                                     input logic [4:0] rt, input bit rt_read);
        return (d != 5'd0) && ((d == rs) || (rt_read && (d == rt)));
    endfunction

    task automatic drive_producers(input prod_t e, input prod_t m);
        br_if.RegWriteE = (e.kind != 0);
        br_if.MemtoRegE = (e.kind == 2) ? 1'b1 : ((e.kind == 1) ? 1'b0 : 1'($urandom));
        br_if.WriteRegE = e.dest;
        br_if.RegWriteM = (m.kind != 0);
        br_if.MemtoRegM = (m.kind == 2) ? 1'b1 : ((m.kind == 1) ? 1'b0 : 1'($urandom));
        br_if.WriteRegM = m.dest;
    endtask

    // Holds the branch in ID while the producers drain down the pipe, one stage per stall.
    task automatic run_branch(input logic [2:0] ty, input logic [4:0] rs, input logic [4:0] rt,
                              input prod_t pe_in, input prod_t pm_in,
                              input logic [31:0] a, input logic [31:0] b,
                              input int hold_at, input bit rand_holds, input string tag);
        prod_t       pe;
        prod_t       pm;
        int          stalls;
        bit          is_br;
        bit          rt_read;
        bit          zero_cmp;
        bit          taken;
        bit          fa;
        bit          fb;
        logic [31:0] b_eff;
        logic [31:0] diff;
        pe       = pe_in;
        pm       = pm_in;
        is_br    = (ty >= 3'd1) && (ty <= 3'd6);
        rt_read  = (ty == 3'd1) || (ty == 3'd2);
        zero_cmp = (ty >= 3'd3) && (ty <= 3'd6);
        b_eff    = zero_cmp ? 32'd0 : b;
        diff     = a - b_eff;
        br_if.BrTypeD = ty;
        br_if.RsD     = rs;
        br_if.RtD     = rt;
        br_if.EqualD  = (a == b_eff);
        br_if.LtzD    = diff[31];

        stalls = 0;
        if (is_br) begin
            if (pe.kind != 0 && reads_reg(pe.dest, rs, rt, rt_read)) stalls = (pe.kind == 2) ? 2 : 1;
            if (pm.kind == 2 && reads_reg(pm.dest, rs, rt, rt_read) && stalls < 1) stalls = 1;
        end

        for (int s = 0; s < stalls; s++) begin
            drive_producers(pe, pm);
            applyStimulus(8'b0001_1100, $sformatf("%s/stall%0d", tag, s), hold_count(s, hold_at, rand_holds));
            pm      = pe;
            pe.kind = 0;
            pe.dest = 5'($urandom_range(0, 31));
        end

        case (ty)
            3'd1:    taken = (a == b);
            3'd2:    taken = (a != b);
            3'd3:    taken = ($signed(a) < 0);
            3'd4:    taken = ($signed(a) >= 0);
            3'd5:    taken = ($signed(a) <= 0);
            3'd6:    taken = ($signed(a) > 0);
            default: taken = 1'b0;
        endcase
        fa = is_br && (pm.kind == 1) && (pm.dest == rs) && (rs != 5'd0);
        fb = is_br && (pm.kind == 1) && (pm.dest == rt) && (rt != 5'd0);
        drive_producers(pe, pm);
        applyStimulus({fa, fb, is_br && zero_cmp, 3'b000, taken, taken}, {tag, "/resolve"},
                      hold_count(stalls, hold_at, rand_holds));
    endtask

    function automatic prod_t random_producer(input logic [4:0] rs, input logic [4:0] rt);
        prod_t p;
        p.kind = int'($urandom_range(0, 2));
        case ($urandom_range(0, 3))
            0:       p.dest = rs;
            1:       p.dest = rt;
            2:       p.dest = 5'd0;
            default: p.dest = 5'($urandom_range(0, 7));
        endcase
        return p;
    endfunction

    initial begin
        prod_t       none_p;
        prod_t       alu_p;
        prod_t       ld_p;
        logic [2:0]  ty;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] a;
        logic [31:0] b;

        none_p.kind = 0; none_p.dest = 5'd0;

        // Reset with a hazarding branch and a hold present: every output must stay low.
        rst_n         = 1'b0;
        br_if.BrTypeD = BR_BEQ;
        br_if.RsD     = 5'd1;
        br_if.RtD     = 5'd2;
        br_if.EqualD  = 1'b1;
        br_if.LtzD    = 1'b0;
        br_if.HoldIn  = 1'b1;
        ld_p.kind = 2; ld_p.dest = 5'd1;
        drive_producers(ld_p, ld_p);
        @(posedge clk);
        #1;
        push_expected(8'h00, "reset", 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        br_if.HoldIn = 1'b0;
        model_stall_cnt = 0;
        model_taken_cnt = 0;

        run_branch(BR_BEQ, 5'd3, 5'd4, none_p, none_p, 32'h1234, 32'h1234, -1, 1'b0, "beqNoHazard");

        ld_p.kind = 2; ld_p.dest = 5'd5;
        run_branch(BR_BNE, 5'd5, 5'd6, ld_p, none_p, 32'd1, 32'd2, -1, 1'b0, "bneLoadUse");

        alu_p.kind = 1; alu_p.dest = 5'd7;
        run_branch(BR_BEQ, 5'd0, 5'd7, alu_p, none_p, 32'd0, 32'd9, -1, 1'b0, "beqAluFwdB");

        alu_p.kind = 1; alu_p.dest = 5'd9;
        run_branch(BR_BLTZ, 5'd8, 5'd9, alu_p, none_p, 32'hFFFF_FFF0, 32'd0, -1, 1'b0, "bltzRtUnused");
        run_branch(BR_BGTZ, 5'd8, 5'd9, none_p, none_p, 32'd0, 32'd0, -1, 1'b0, "bgtzZero");

        ld_p.kind = 2; ld_p.dest = 5'd5;
        run_branch(BR_BNE, 5'd5, 5'd6, ld_p, none_p, 32'd3, 32'd3, 1, 1'b0, "loadUseHold");

        alu_p.kind = 1; alu_p.dest = 5'd4;
        run_branch(BR_RSVD, 5'd4, 5'd4, alu_p, ld_p, 32'd0, 32'd0, -1, 1'b0, "reservedType");
        run_branch(BR_NONE, 5'd4, 5'd4, alu_p, ld_p, 32'd0, 32'd0, -1, 1'b0, "noneType");

        // Reset arriving mid-WAIT must abandon the branch without a taken decision.
        ld_p.kind = 2; ld_p.dest = 5'd5;
        br_if.BrTypeD = BR_BNE;
        br_if.RsD     = 5'd5;
        br_if.RtD     = 5'd6;
        br_if.EqualD  = 1'b0;
        br_if.LtzD    = 1'b0;
        drive_producers(ld_p, none_p);
        applyStimulus(8'b0001_1100, "rstWait/stall0", 0);
        rst_n = 1'b0;
        push_expected(8'h00, "rstWait/inReset", 1'b0);
        @(posedge clk);
        #1;
        model_stall_cnt = 0;
        model_taken_cnt = 0;
        rst_n = 1'b1;
        br_if.BrTypeD = BR_NONE;
        applyStimulus(8'h00, "rstWait/idleAfter", 0);

        for (int n = 0; n < 200; n++) begin
            ty = 3'($urandom_range(0, 7));
            rs = 5'($urandom_range(0, 7));
            rt = 5'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       a = 32'd0;
                1:       a = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 1) == 0) ? a : $urandom;
            run_branch(ty, rs, rt, random_producer(rs, rt), random_producer(rs, rt), a, b,
                       -1, 1'b1, $sformatf("rand%0d", n));
        end

        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

`ifdef BRCTRL_PERF_EN
        tests_run++;
        if (br_if.BrStallCnt !== model_stall_cnt) begin
            tests_failed++;
            $display("[TB] FAIL BrStallCnt: got %0d, expected %0d", br_if.BrStallCnt, model_stall_cnt);
        end
        tests_run++;
        if (br_if.BrTakenCnt !== model_taken_cnt) begin
            tests_failed++;
            $display("[TB] FAIL BrTakenCnt: got %0d, expected %0d", br_if.BrTakenCnt, model_taken_cnt);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
